// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination lock.
// The state encoding is visible on the lock's state output, so these
// values are part of the interface and must not be reordered.
package combo_lock_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 2'd0,
        ENTRY    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_e;

    // Width of a down-counter that holds values 0 .. cycles-1 (at least 1 bit).
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/combo_lock_timer.sv
// Loadable down-counter shared by the unlock window and the lockout period.
// zero_o reports the registered count, so a load of N-1 yields N cycles
// before the owner sees zero and leaves its state.
module combo_lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins, otherwise decrement without wrapping below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_param.sv
// Parametrised serial combination lock with unlock window, failure counting
// and timed lockout. Bits arrive MSB first, one per bit_valid strobe.
// Optional macro COMBO_LOCK_REPROG_EN adds prog/prog_busy so the stored code
// can be rewritten from the unlocked state; without it the code is fixed.
// All outputs come straight from flops.
module combo_lock_param
    import combo_lock_pkg::*;
#(
    parameter int                CODE_LEN       = 5,
    parameter logic [CODE_LEN-1:0] CODE_DEFAULT = 5'b01011,
    parameter int                MAX_FAILS      = 3,
    parameter int                UNLOCK_CYCLES  = 8,
    parameter int                LOCKOUT_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               bit_valid,
    input  logic                               bit_in,
    input  logic                               abort,
    input  logic                               relock,
    output logic                               unlocked,
    output logic                               lockout,
    output logic [STATE_W-1:0]                 state,
    output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count,
    output logic [$clog2(CODE_LEN+1)-1:0]      progress
`ifdef COMBO_LOCK_REPROG_EN
    ,
    input  logic                               prog,
    output logic                               prog_busy
`endif
);

    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int PROG_W  = $clog2(CODE_LEN + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = cnt_width(TMR_MAX);

    // Only CODE_LEN-1 bits need storing: the final bit is combined on the fly.
    state_e              state_q, state_d;
    logic [CODE_LEN-2:0] entry_q, entry_d;
    logic [PROG_W-1:0]   progress_q, progress_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                unlocked_q, lockout_q;
    logic [CODE_LEN-1:0] entry_shift;
    logic [CODE_LEN-1:0] stored_code;
    logic                last_bit;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_value;

`ifdef COMBO_LOCK_REPROG_EN
    logic                prog_q, prog_d;
    logic                prog_busy_q;
    logic [CODE_LEN-1:0] code_q, code_d;
    assign stored_code = code_q;
`else
    assign stored_code = CODE_DEFAULT;
`endif

    assign entry_shift = {entry_q, bit_in};
    assign last_bit    = (progress_q == PROG_W'(CODE_LEN - 1));

    combo_lock_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    // State register plus the registered copies of the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            progress_q  <= '0;
            fail_q      <= '0;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
`ifdef COMBO_LOCK_REPROG_EN
            prog_q      <= 1'b0;
            prog_busy_q <= 1'b0;
            code_q      <= CODE_DEFAULT;
`endif
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            progress_q  <= progress_d;
            fail_q      <= fail_d;
            unlocked_q  <= (state_d == UNLOCKED);
            lockout_q   <= (state_d == LOCKOUT);
`ifdef COMBO_LOCK_REPROG_EN
            prog_q      <= prog_d;
            prog_busy_q <= prog_d;
            code_q      <= code_d;
`endif
        end
    end

    // Next-state logic: key entry, attempt evaluation and the timed states.
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        tmr_dec    = 1'b0;
`ifdef COMBO_LOCK_REPROG_EN
        prog_d     = prog_q;
        code_d     = code_q;
`endif
        case (state_q)
            IDLE: begin
                if (bit_valid) begin
                    entry_d    = entry_shift[CODE_LEN-2:0];
                    progress_d = PROG_W'(1);
                    state_d    = ENTRY;
                end
            end
            ENTRY: begin
                // abort beats a simultaneous strobe and is never a failure
                if (abort) begin
                    progress_d = '0;
                    state_d    = IDLE;
                end else if (bit_valid) begin
                    entry_d = entry_shift[CODE_LEN-2:0];
                    if (last_bit) begin
                        progress_d = '0;
                        if (entry_shift == stored_code) begin
                            fail_d    = '0;
                            state_d   = UNLOCKED;
                            tmr_load  = 1'b1;
                            tmr_value = TMR_W'(UNLOCK_CYCLES - 1);
                        end else if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
                            fail_d    = FAIL_W'(MAX_FAILS);
                            state_d   = LOCKOUT;
                            tmr_load  = 1'b1;
                            tmr_value = TMR_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d  = fail_q + FAIL_W'(1);
                            state_d = IDLE;
                        end
                    end else begin
                        progress_d = progress_q + PROG_W'(1);
                    end
                end
            end
            UNLOCKED: begin
`ifdef COMBO_LOCK_REPROG_EN
                // programming freezes the window until the new code is in or abort
                if (prog_q) begin
                    if (abort) begin
                        prog_d     = 1'b0;
                        progress_d = '0;
                        state_d    = IDLE;
                    end else if (bit_valid) begin
                        entry_d = entry_shift[CODE_LEN-2:0];
                        if (last_bit) begin
                            code_d     = entry_shift;
                            prog_d     = 1'b0;
                            progress_d = '0;
                            state_d    = IDLE;
                        end else begin
                            progress_d = progress_q + PROG_W'(1);
                        end
                    end
                end else if (prog) begin
                    prog_d     = 1'b1;
                    progress_d = '0;
                end else
`endif
                if (relock || tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: drive ports from their registers.
    always_comb begin
        state      = state_q;
        unlocked   = unlocked_q;
        lockout    = lockout_q;
        fail_count = fail_q;
        progress   = progress_q;
`ifdef COMBO_LOCK_REPROG_EN
        prog_busy  = prog_busy_q;
`endif
    end

endmodule
